// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and grant helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [4:0] {
        ARB_IDLE      = 5'b00001,
        ARB_INST_REQ  = 5'b00010,
        ARB_INST_RESP = 5'b00100,
        ARB_DATA_REQ  = 5'b01000,
        ARB_DATA_RESP = 5'b10000
    } arb_state_e;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } arb_gnt_e;

    // On a tie the requester that did not win last time gets the port.
    function automatic arb_gnt_e pick_grant(input logic inst_req, input logic data_req,
                                            input arb_gnt_e last_grant);
        arb_gnt_e gnt;
        gnt = GNT_INST;
        if (inst_req && data_req) begin
            if (last_grant == GNT_INST) begin
                gnt = GNT_DATA;
            end
        end else if (data_req) begin
            gnt = GNT_DATA;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// rtl/mem_port_arbiter_wait_counter.sv - wrapping enable counter used for per-requester stall statistics
module arb_wait_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data load/store
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic                inst_req_valid,
    output logic                inst_req_ack,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_rvalid,
    input  logic                inst_rack,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic                data_wen,
    input  logic                data_ren,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic                data_req_ack,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_rvalid,
    input  logic                data_rack,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic                mem_ren,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_req_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rvalid,
    output logic                mem_rack,
    output logic [CNT_W-1:0]    inst_wait_cnt,
    output logic [CNT_W-1:0]    data_wait_cnt
);

    arb_state_e state_q;
    arb_state_e state_d;
    arb_gnt_e   last_grant_q;
    arb_gnt_e   last_grant_d;
    arb_gnt_e   gnt;
    logic       data_req;

    assign data_req = data_wen | data_ren;
    assign gnt      = pick_grant(inst_req_valid, data_req, last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (inst_req_valid || data_req) begin
                    last_grant_d = gnt;
                    state_d      = (gnt == GNT_DATA) ? ARB_DATA_REQ : ARB_INST_REQ;
                end
            end
            ARB_INST_REQ: begin
                if (mem_req_ack) state_d = ARB_INST_RESP;
            end
            ARB_INST_RESP: begin
                if (mem_rvalid && inst_rack) state_d = ARB_IDLE;
            end
            ARB_DATA_REQ: begin
                // Stores complete on the request handshake; only loads wait for data.
                if (mem_req_ack) state_d = data_wen ? ARB_IDLE : ARB_DATA_RESP;
            end
            ARB_DATA_RESP: begin
                if (mem_rvalid && data_rack) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GNT_INST;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Everything is steered from the registered state; unrouted outputs read as zero.
    always_comb begin
        mem_addr     = '0;
        mem_wen      = 1'b0;
        mem_ren      = 1'b0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        mem_rack     = 1'b0;
        inst_req_ack = 1'b0;
        inst_rdata   = '0;
        inst_rvalid  = 1'b0;
        data_req_ack = 1'b0;
        data_rdata   = '0;
        data_rvalid  = 1'b0;
        unique case (state_q)
            ARB_INST_REQ: begin
                mem_ren      = 1'b1;
                mem_addr     = inst_addr;
                inst_req_ack = mem_req_ack;
            end
            ARB_INST_RESP: begin
                inst_rvalid = mem_rvalid;
                inst_rdata  = mem_rdata;
                mem_rack    = inst_rack;
            end
            ARB_DATA_REQ: begin
                mem_addr     = data_addr;
                mem_wen      = data_wen;
                mem_ren      = data_ren & ~data_wen;
                mem_wdata    = data_wdata;
                mem_wstrb    = data_wstrb;
                data_req_ack = mem_req_ack;
            end
            ARB_DATA_RESP: begin
                data_rvalid = mem_rvalid;
                data_rdata  = mem_rdata;
                mem_rack    = data_rack;
            end
            default: begin
            end
        endcase
    end

    arb_wait_counter #(.CNT_W(CNT_W)) u_inst_wait (
        .clk   (clk),
        .rst   (rst),
        .en_i  (inst_req_valid & ~inst_req_ack),
        .cnt_o (inst_wait_cnt)
    );

    arb_wait_counter #(.CNT_W(CNT_W)) u_data_wait (
        .clk   (clk),
        .rst   (rst),
        .en_i  (data_req & ~data_req_ack),
        .cnt_o (data_wait_cnt)
    );

endmodule
